// File: rtl/ram_handshake_unit.sv
// Byte-addressable big-endian RAM answering the MFA/MFC handshake with programmable wait states.
// Optional `MISALIGN_TRAP_EN: misaligned halfword/word accesses raise ERR instead of aligning down.
module ram_handshake_unit #(
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        CLR,
    input  logic        MFA,
    input  logic        RW,
    input  logic [1:0]  MAS,
    input  logic [31:0] ADDR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MFC,
    output logic        BUSY,
    output logic        ERR
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic          rw;
        logic [1:0]    mas;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } req_t;

    logic [7:0]    mem [DEPTH] = '{default: 8'h00};
    logic [1:0]    state;
    logic [3:0]    cnt;
    req_t          req;
    logic [AW-1:0] ab;
    logic [7:0]    rb [4];
    logic [7:0]    wb [4];
    logic [3:0]    we;
    logic [31:0]   rdata;
    logic          trap;
    logic          err_q;
    logic          access;
    logic          unused_hi;

    assign unused_hi = ^ADDR[31:AW];

    // MAS=11 behaves as a word; base address is aligned down so an access never straddles
    always_comb begin
        ab = req.addr;
        if (req.mas == 2'b01) ab[0] = 1'b0;
        else if (req.mas[1])  ab[1:0] = 2'b00;
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = (req.mas == 2'b01 && req.addr[0]) || (req.mas[1] && req.addr[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            rb[i] = mem[ab + AW'(i)];
            wb[i] = 8'h00;
        end
        we    = 4'b0000;
        rdata = 32'h0;
        case (req.mas)
            2'b00: begin
                we    = 4'b0001;
                wb[0] = req.data[7:0];
                rdata = {24'h0, rb[0]};
            end
            2'b01: begin
                we    = 4'b0011;
                wb[0] = req.data[15:8];
                wb[1] = req.data[7:0];
                rdata = {16'h0, rb[0], rb[1]};
            end
            default: begin
                we    = 4'b1111;
                wb[0] = req.data[31:24];
                wb[1] = req.data[23:16];
                wb[2] = req.data[15:8];
                wb[3] = req.data[7:0];
                rdata = {rb[0], rb[1], rb[2], rb[3]};
            end
        endcase
    end

    assign access = (state == S_WAIT) && (cnt == 4'd0);

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            req     <= '0;
            DataOut <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (MFA) begin
                    req   <= '{rw: RW, mas: MAS, addr: ADDR[AW-1:0], data: DataIn};
                    cnt   <= 4'(WAIT_CYCLES);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                    else begin
                        state <= S_DONE;
                        err_q <= trap;
                        if (req.rw && !trap) DataOut <= rdata;
                    end
                end
                S_DONE: if (!MFA) begin
                    state <= S_IDLE;
                    err_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM is not reset; CLR low on the commit edge drops the write
    always_ff @(posedge clk) begin
        if (CLR && access && !req.rw && !trap)
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[ab + AW'(i)] <= wb[i];
    end

    assign MFC  = (state == S_DONE);
    assign BUSY = (state != S_IDLE);
    assign ERR  = err_q;
endmodule

// File: tb/tb_ram_handshake_unit.sv
// Randomized + directed bench for ram_handshake_unit against a byte-array reference model.
module tb_ram_handshake_unit;
    localparam int DEPTH = 512;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        CLR = 1'b0;
    logic        MFA = 1'b0;
    logic        RW = 1'b0;
    logic [1:0]  MAS = 2'b00;
    logic [31:0] ADDR = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic        MFC, BUSY, ERR;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mem_m [DEPTH];
    logic [31:0] dout_m = '0;

    ram_handshake_unit #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .CLR(CLR), .MFA(MFA), .RW(RW), .MAS(MAS), .ADDR(ADDR),
        .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic access(input bit rw, input logic [1:0] mas, input logic [31:0] addr,
                          input logic [31:0] data, input int hold);
        int  sz, base, lat;
        bit  mis, got;
        logic [31:0] v;
        sz   = (mas == 2'b00) ? 1 : (mas == 2'b01) ? 2 : 4;
        base = int'(addr % DEPTH) / sz * sz;
`ifdef MISALIGN_TRAP_EN
        mis = (addr % sz) != 0;
`else
        mis = 1'b0;
`endif
        if (!mis) begin
            if (rw) begin
                v = 0;
                for (int k = 0; k < sz; k++) v = (v << 8) | 32'(mem_m[base + k]);
                dout_m = v;
            end else begin
                for (int k = 0; k < sz; k++) mem_m[base + k] = 8'((data >> (8 * (sz - 1 - k))) & 32'hFF);
            end
        end
        @(negedge clk);
        MFA = 1'b1; RW = rw; MAS = mas; ADDR = addr; DataIn = data;
        got = 1'b0; lat = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                check("busy_on_accept", 32'(BUSY), 1);
                RW = ~rw; MAS = 2'($urandom); ADDR = $urandom; DataIn = $urandom;
            end
            if (MFC) begin got = 1'b1; lat = e; break; end
        end
        if (!got) check("mfc_timeout", 0, 1);
        else check("mfc_latency", 32'(lat), W + 1);
        check("dataout", DataOut, dout_m);
        check("err_with_mfc", 32'(ERR), 32'(mis));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("mfc_held", 32'(MFC), 1);
        end
        MFA = 1'b0;
        @(posedge clk); #1;
        check("mfc_drop", 32'(MFC), 0);
        check("busy_drop", 32'(BUSY), 0);
        check("err_drop", 32'(ERR), 0);
    endtask

    task automatic read_word(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        access(1'b1, 2'b10, addr, $urandom, 0);
        check(tag, DataOut, exp);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        #3;
        check("rst_mfc", 32'(MFC), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_err", 32'(ERR), 0);
        check("rst_dout", DataOut, 0);
        CLR = 1'b1;

        access(1'b0, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        read_word(32'h10, 32'hDEADBEEF, "word_rd_10");
        access(1'b1, 2'b00, 32'h11, 32'h0, 0);
        check("byte_rd_11", DataOut, 32'h000000AD);
        access(1'b1, 2'b01, 32'h12, 32'h0, 0);
        check("half_rd_12", DataOut, 32'h0000BEEF);
        access(1'b0, 2'b00, 32'h13, 32'hFFFFFF55, 0);
        check("dout_after_write", DataOut, 32'h0000BEEF);
        read_word(32'h10, 32'hDEADBE55, "word_rd_merge");
        access(1'b1, 2'b10, 32'h10, 32'h0, 5);

        // reset during WAIT of a write: write dropped, outputs cleared at once
        access(1'b0, 2'b10, 32'h20, 32'hA1B2C3D4, 0);
        @(negedge clk);
        MFA = 1'b1; RW = 1'b0; MAS = 2'b10; ADDR = 32'h20; DataIn = 32'h12345678;
        @(posedge clk); #2;
        CLR = 1'b0; #1;
        check("clr_mfc", 32'(MFC), 0);
        check("clr_busy", 32'(BUSY), 0);
        check("clr_dout", DataOut, 0);
        dout_m = 32'h0;
        MFA = 1'b0; #1;
        CLR = 1'b1;
        read_word(32'h20, 32'hA1B2C3D4, "rd_after_clr");

        access(1'b1, 2'b10, 32'h22, 32'h0, 1);
`ifdef MISALIGN_TRAP_EN
        check("misalign_dout", DataOut, 32'hA1B2C3D4);
`else
        check("aligndown_dout", DataOut, 32'hA1B2C3D4);
`endif
        access(1'b0, 2'b10, 32'(DEPTH + 4), 32'hCAFEF00D, 0);
        read_word(32'h4, 32'hCAFEF00D, "wrap_rd_4");

        for (int t = 0; t < 120; t++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 31));
            access(($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1, 2'($urandom), a, $urandom,
                   $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
